// File: rtl/gpp_prog_loader.sv
// Streams a length-prefixed, checksummed byte image into the GPP program memory
// and holds the core in reset until a complete, verified image has been written.
module gpp_prog_loader #(
    parameter int DEPTH   = 128,
    parameter int AW      = 8,
    parameter int TIMEOUT = 50000000
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          start,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          core_rst_,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    hi_q, hi_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    code_q, code_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          loading, xfer;

    assign loading = (state_q == S_LEN) || (state_q == S_HI) ||
                     (state_q == S_LO)  || (state_q == S_CSUM);
    assign xfer    = loading && in_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        code_d  = code_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = '0;
        if (loading && !xfer) tmo_d = tmo_q + TW'(1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    code_d  = 2'd0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (in_byte == 8'd0 || {1'b0, in_byte} > 9'(DEPTH)) begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end else begin
                        len_d   = in_byte;
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = in_byte;
                    sum_d   = sum_q + in_byte;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                // Write is registered; the FSM keeps accepting bytes during the strobe.
                if (xfer) begin
                    sum_d   = sum_q + in_byte;
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = {hi_q, in_byte};
                    idx_d   = idx_q + AW'(1);
                    if ((AW+1)'(idx_q) + (AW+1)'(1) == (AW+1)'(len_q)) state_d = S_CSUM;
                    else                                                state_d = S_HI;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (in_byte == sum_q) state_d = S_DONE;
                    else begin
                        state_d = S_ERR;
                        code_d  = 2'd2;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (loading && !xfer && tmo_d == TW'(TIMEOUT)) begin
            state_d = S_ERR;
            code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
            tmo_q   <= '0;
            code_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = loading;
    assign busy      = loading;
    assign done      = (state_q == S_DONE);
    assign core_rst_ = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign err_code  = code_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule
